dac_frame_serializer: RTL and testbench

Output stage directly downstream of the IIR filter datapath. Captures the filter's 32-bit signed output `yn` on a sample strobe, scales and saturates it to a 12-bit offset-binary DAC code, and shifts a 16-bit command frame MSB-first to an external SPI DAC. Sample-rate strobes that arrive while a frame is in flight are dropped and flagged.

---
 rtl/dac_frame_serializer.sv | 115 +++++++++++
 tb/tb_dac_frame_serializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_serializer.sv
// dac_frame_serializer: scales/saturates a 32-bit signed filter sample to a 12-bit offset-binary code and shifts {CMD, code} MSB-first to an SPI DAC.
// Ports: clk, rst (sync, active-high), sample_valid/yn (sample strobe and data), ready (idle, strobe accepted),
//        drop (strobe ignored while busy), clipped (saturation on the captured sample), cs_n/sclk/mosi (SPI),
//        ldac_n (DAC load strobe, only when DAC_LDAC_EN is defined; adds an LDAC state after HOLD).
module dac_frame_serializer #(
  parameter int SHIFT = 16,
  parameter int CLK_DIV = 2,
  parameter logic [3:0] CMD = 4'h3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic signed [31:0] yn,
  output logic               ready,
  output logic               drop,
  output logic               clipped,
  output logic               cs_n,
  output logic               sclk,
  output logic               mosi
`ifdef DAC_LDAC_EN
  ,
  output logic               ldac_n
`endif
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
`ifdef DAC_LDAC_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD, S_LDAC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;
`endif
  state_t state, state_n;
  logic [15:0] frame, frame_n;
  logic [3:0] bit_cnt, bit_n;
  logic [DW-1:0] div_cnt, div_n;
  logic phase, phase_n;
  logic div_end, accept, clip;
  logic signed [31:0] s;
  logic signed [32:0] sum;
  logic [11:0] code;
  // sum is one bit wider so a small SHIFT cannot overflow when the offset is added
  always_comb begin
    s = yn >>> SHIFT;
    sum = {s[31], s} + 33'sd2048;
    clip = sum < 33'sd0 || sum > 33'sd4095;
    code = sum < 33'sd0 ? 12'h000 : sum > 33'sd4095 ? 12'hfff : sum[11:0];
  end
  assign accept = ready & sample_valid;
  assign div_end = div_cnt == DIV_END;
  always_comb begin
    state_n = state;
    frame_n = frame;
    bit_n = bit_cnt;
    div_n = div_cnt;
    phase_n = phase;
    case (state)
      S_IDLE: begin
        state_n = accept ? S_SHIFT : S_IDLE;
        frame_n = accept ? {CMD, code} : frame;
        bit_n = 4'd15;
        div_n = '0;
        phase_n = 1'b0;
      end
      S_SHIFT: begin
        div_n = div_end ? '0 : div_cnt + 1'b1;
        phase_n = phase ^ div_end;
        bit_n = phase && div_end ? bit_cnt - 1'b1 : bit_cnt;
        state_n = phase && div_end && bit_cnt == 4'd0 ? S_HOLD : S_SHIFT;
      end
      S_HOLD: begin
        div_n = div_end ? '0 : div_cnt + 1'b1;
`ifdef DAC_LDAC_EN
        state_n = div_end ? S_LDAC : S_HOLD;
`else
        state_n = div_end ? S_IDLE : S_HOLD;
`endif
      end
`ifdef DAC_LDAC_EN
      S_LDAC: begin
        div_n = div_end ? '0 : div_cnt + 1'b1;
        state_n = div_end ? S_IDLE : S_LDAC;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end
  // ready is a register so it stays low during reset even though the state is IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      frame <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      phase <= 1'b0;
      ready <= 1'b0;
      drop <= 1'b0;
      clipped <= 1'b0;
    end else begin
      state <= state_n;
      frame <= frame_n;
      bit_cnt <= bit_n;
      div_cnt <= div_n;
      phase <= phase_n;
      ready <= state_n == S_IDLE;
      drop <= sample_valid & ~ready;
      clipped <= accept & clip;
    end
  end
  assign cs_n = state != S_SHIFT;
  assign sclk = state == S_SHIFT && phase;
  assign mosi = state == S_SHIFT && frame[bit_cnt];
`ifdef DAC_LDAC_EN
  assign ldac_n = state != S_LDAC;
`endif
endmodule

// File: tb/tb_dac_frame_serializer.sv
// tb_dac_frame_serializer: randomized scoreboard bench for dac_frame_serializer (SPI frames, clipping, drops, reset abort).
module tb_dac_frame_serializer;
  localparam int CD = 2;
  localparam int SH = 16;
`ifdef DAC_LDAC_EN
  localparam int RDY = 34 * CD + 1;
`else
  localparam int RDY = 33 * CD + 1;
`endif
  typedef struct packed {
    logic abort;
    logic clip;
    logic [15:0] frame;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_valid = 1'b0;
  logic [31:0] yn = '0;
  logic ready, drop, clipped, cs_n, sclk, mosi;
`ifdef DAC_LDAC_EN
  logic ldac_n;
`endif
  int tests = 0;
  int fails = 0;
  item_t sb[$];
  logic m_pc = 1'b1;
  logic m_ps = 1'b0;
  logic [15:0] m_sr = '0;
  int m_nb = 0;
  int m_low = 0;
  dac_frame_serializer #(.SHIFT(SH), .CLK_DIV(CD), .CMD(4'h3)) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .yn(yn),
    .ready(ready),
    .drop(drop),
    .clipped(clipped),
    .cs_n(cs_n),
    .sclk(sclk),
    .mosi(mosi)
`ifdef DAC_LDAC_EN
    ,
    .ldac_n(ldac_n)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // floor(y / 2^SH) + 2048 clamped to 0..4095, prefixed by the command nibble
  function automatic logic [16:0] model(input logic [31:0] y);
    longint v, d, q;
    logic c;
    v = longint'($signed(y));
    d = longint'(1) << SH;
    q = v / d;
    if (v < 0 && q * d != v) q = q - 1;
    q = q + 2048;
    c = q < 0 || q > 4095;
    if (q < 0) q = 0;
    if (q > 4095) q = 4095;
    return {c, 4'h3, q[11:0]};
  endfunction
  function automatic logic [31:0] rnd_y();
    int v;
    if ($urandom_range(0, 2) == 0) return $urandom;
    v = int'($urandom_range(0, 9000)) - 4500;
    return 32'(v <<< 16) | 32'($urandom_range(0, 65535));
  endfunction
  task automatic frame(input logic [31:0] y, input int drop_at, input int rst_at);
    logic [16:0] m;
    item_t it;
    int n, lfirst, lcnt;
    m = model(y);
    it.abort = rst_at != 0;
    it.clip = m[16];
    it.frame = m[15:0];
    sb.push_back(it);
    sample_valid = 1'b1;
    yn = y;
    n = 0;
    lfirst = 0;
    lcnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        sample_valid = 1'b0;
        chk("ready_busy", ready, 0);
        chk("cs_n_start", cs_n, 0);
      end
      if (drop_at != 0 && n == drop_at) begin
        sample_valid = 1'b1;
        yn = $urandom;
      end
      if (drop_at != 0 && n == drop_at + 1) begin
        sample_valid = 1'b0;
        chk("drop_pulse", drop, 1);
      end
      if (rst_at != 0 && n == rst_at) rst = 1'b1;
      if (rst_at != 0 && n == rst_at + 1) begin
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_ready", ready, 0);
        rst = 1'b0;
      end
`ifdef DAC_LDAC_EN
      if (!ldac_n) begin
        if (lcnt == 0) lfirst = n;
        lcnt++;
      end
`endif
    end while (!ready && n < 300);
    if (rst_at == 0) chk("ready_latency", n, RDY);
    else chk("ready_after_abort", n, rst_at + 2);
`ifdef DAC_LDAC_EN
    if (rst_at == 0) begin
      chk("ldac_start", lfirst, 33 * CD + 1);
      chk("ldac_len", lcnt, CD);
    end else chk("ldac_none", lcnt, 0);
`endif
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (m_pc && !cs_n) begin
        m_nb = 0;
        m_low = 0;
        m_sr = '0;
        chk("sb_has_item", sb.size() != 0, 1);
        if (sb.size() != 0) chk("clipped", clipped, sb[0].clip);
      end
      if (!cs_n) begin
        m_low++;
        if (sclk && !m_ps) begin
          m_sr = {m_sr[14:0], mosi};
          m_nb++;
        end
      end
      if (!m_pc && cs_n) begin
        chk("sb_has_item", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          item_t it;
          it = sb.pop_front();
          if (!it.abort) begin
            chk("frame", m_sr, it.frame);
            chk("sclk_edges", m_nb, 16);
            chk("cs_n_low_len", m_low, 32 * CD);
          end
        end
      end
      m_pc = cs_n;
      m_ps = sclk;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_drop", drop, 0);
    chk("rst_clipped", clipped, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
`ifdef DAC_LDAC_EN
    chk("rst_ldac_n", ldac_n, 1);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ready, 1);
    frame(32'h0000_0000, 0, 0);
    frame(32'h0001_0000, 0, 0);
    frame(32'hffff_0000, 0, 0);
    frame(32'h7fff_ffff, 0, 0);
    frame(32'h8000_0000, 0, 0);
    frame(rnd_y(), 10, 0);
    frame(rnd_y(), RDY - 2, 0);
    frame(rnd_y(), 0, 20);
    frame(rnd_y(), 0, 0);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      frame(rnd_y(), $urandom_range(0, 1) == 1 ? int'($urandom_range(2, RDY - 2)) : 0, 0);
    end
    repeat (10) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
